bus_xfer_mux: RTL and testbench
===============================

// Module: bus_xfer_mux
// PURPOSE
//  Parametrised, registered datapath bus for the core. Each cycle selects one of NUM_SRC
//  register/memory sources by read code. Drives it onto busout one clock later, with a
//  one-hot write-enable to one of NUM_DST destinations aligned to that data.
//  Adds stall hold, out-of-range select detection and a transfer counter.
//  Sits between the control unit (rd_sel/wr_sel) and the register file/RAM ports.
// PARAMETERS
//  DATA_W   16  bus data width
//  NUM_SRC  11  source count; read code c (1..NUM_SRC) selects src index c-1
//  NUM_DST  11  destination count; write code c (1..NUM_DST) enables wr_en[c-1]
//  SEL_W    4   select code width; must satisfy 2**SEL_W > max(NUM_SRC,NUM_DST)
//  CNT_W    16  transfer counter width
// PORTS
//  clock     in   1               rising-edge clock
//  reset_n   in   1               asynchronous, active-low reset
//  src_data  in   NUM_SRC*DATA_W  packed sources; src i at [i*DATA_W +: DATA_W]
//  rd_sel    in   SEL_W           read code; 0 = idle
//  wr_sel    in   SEL_W           write code; 0 = no write
//  stall     in   1               1 = hold all registered outputs
//  err_clr   in   1               clears sel_err
//  busout    out  DATA_W          registered bus value
//  bus_valid out  1               busout carries a selected source
//  bus_src   out  SEL_W           read code that produced busout
//  wr_en     out  NUM_DST         registered one-hot write enable, aligned with busout
//  sel_err   out  1               sticky out-of-range select flag
//  xfer_cnt  out  CNT_W           completed-transfer count
// BEHAVIOUR
//  - Reset (async, reset_n=0): busout=0, bus_valid=0, bus_src=0, wr_en=0, sel_err=0,
//    xfer_cnt=0. Release is synchronous to the next rising clock edge.
//  - Latency 1: rd_sel/wr_sel/src_data sampled at edge N; outputs valid after edge N.
//  - rd_sel=0: busout<=0, bus_valid<=0. rd_sel in 1..NUM_SRC: busout<=src[rd_sel-1],
//    bus_valid<=1. rd_sel>NUM_SRC: busout<=0, bus_valid<=0, sel_err<=1.
//  - bus_src<=rd_sel whenever the registers update, including 0 and out-of-range.
//  - wr_sel=0: wr_en<=0. wr_sel in 1..NUM_DST: wr_en<=1<<(wr_sel-1); asserts even when
//    bus_valid=0, so the destination loads 0. wr_sel>NUM_DST: wr_en<=0, sel_err<=1.
//  - stall=1: busout, bus_valid, bus_src and wr_en hold their values; selects are not
//    sampled. No new sel_err is raised and xfer_cnt does not count. Held wr_en stays
//    asserted; the destination sees a repeated write of the same data.
//  - sel_err is sticky. err_clr=1 clears it. A same-cycle new error wins over err_clr.
//  - xfer_cnt increments at each non-stalled edge where the new bus_valid=1 and the new
//    wr_en!=0. Wraps 2**CNT_W-1 -> 0 silently.
//  - src_data changes only matter at sampling edges; no combinational path to outputs.
// CONFIGURATION
//  BUS_XFER_CNT_EN defined: xfer_cnt counter built as above.
//  Not defined: no counter flops; xfer_cnt tied to 0. All else is unchanged.
// STRUCTURE
//  bus_pkg: BUS_CODE_IDLE=0, default DATA_W/SEL_W, and the code->index helper function
//  (code-1, with range check).
//  Sub-module bus_sel_decode(SEL_W, N): code -> one-hot[N] plus out_of_range bit.
//  Instantiated twice: read side (mux select) and write side (wr_en).
//  Top holds the output registers, stall gating, sel_err and the counter.
// TESTING
//  1 Reset: drive reset_n=0 mid-transfer with wr_en active -> all outputs 0 immediately,
//    without waiting for a clock edge.
//  2 Defaults: src[0]=16'h1234, rd_sel=1, wr_sel=3 -> next cycle: busout=16'h1234,
//    bus_valid=1, bus_src=1, wr_en=11'b100, xfer_cnt=1.
//  3 Stall: stall=1 for 3 cycles while rd_sel changes -> busout, wr_en and xfer_cnt
//    frozen; after stall=0 the new select appears 1 cycle later.
//  4 Out-of-range: rd_sel=12 -> busout=0, bus_valid=0, sel_err=1. err_clr=1 with
//    wr_sel=15 in the same cycle -> sel_err stays 1. err_clr alone -> sel_err=0.
//  5 Idle write: rd_sel=0, wr_sel=2 -> busout=0, wr_en=11'b10, xfer_cnt unchanged.
//  6 Wrap and macro: CNT_W=4, 17 transfers -> xfer_cnt=1. Build without
//    BUS_XFER_CNT_EN -> xfer_cnt always 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and the select-code to index helper for the bus transfer mux.
package bus_pkg;

  localparam int BUS_CODE_IDLE = 0;
  localparam int DATA_W_DEF    = 16;
  localparam int SEL_W_DEF     = 4;

  // Returns code-1 for a code in 1..n, otherwise -1 (idle or out of range).
  function automatic int code_to_idx(input int code, input int n);
    if (code >= 1 && code <= n) return code - 1;
    else                        return -1;
  endfunction

endpackage

// File: rtl/bus_sel_decode.sv
// Select code to one-hot decoder with out-of-range flag; code 0 is idle.
module bus_sel_decode
  import bus_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int N     = 11
) (
  input  logic [SEL_W-1:0] code_i,
  output logic [N-1:0]     onehot_o,
  output logic             oor_o
);

  int idx;

  always_comb begin
    onehot_o = '0;
    oor_o    = 1'b0;
    idx      = code_to_idx(int'(code_i), N);
    if (int'(code_i) != BUS_CODE_IDLE && idx < 0) oor_o = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (idx == i) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_mux.sv
// Registered source-select bus with aligned one-hot write enable, stall hold and sticky select error.
// Optional transfer counter built only when BUS_XFER_CNT_EN is defined; otherwise xfer_cnt is 0.
module bus_xfer_mux
  import bus_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_SRC = 11,
  parameter int NUM_DST = 11,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          rd_sel,
  input  logic [SEL_W-1:0]          wr_sel,
  input  logic                      stall,
  input  logic                      err_clr,
  output logic [DATA_W-1:0]         busout,
  output logic                      bus_valid,
  output logic [SEL_W-1:0]          bus_src,
  output logic [NUM_DST-1:0]        wr_en,
  output logic                      sel_err,
  output logic [CNT_W-1:0]          xfer_cnt
);

  logic [NUM_SRC-1:0] rd_oh;
  logic [NUM_DST-1:0] wr_oh;
  logic               rd_oor, wr_oor;

  logic [DATA_W-1:0]  busout_d, busout_q;
  logic               valid_d, valid_q;
  logic [SEL_W-1:0]   src_q;
  logic [NUM_DST-1:0] wr_en_q;
  logic               sel_err_q;

  bus_sel_decode #(.SEL_W(SEL_W), .N(NUM_SRC)) u_rd_dec (
    .code_i(rd_sel), .onehot_o(rd_oh), .oor_o(rd_oor)
  );

  bus_sel_decode #(.SEL_W(SEL_W), .N(NUM_DST)) u_wr_dec (
    .code_i(wr_sel), .onehot_o(wr_oh), .oor_o(wr_oor)
  );

  // AND-OR mux: an idle or out-of-range code yields an all-zero one-hot, hence zero data.
  always_comb begin
    busout_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rd_oh[i]) busout_d = busout_d | src_data[i*DATA_W +: DATA_W];
    end
    valid_d = |rd_oh;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busout_q  <= '0;
      valid_q   <= 1'b0;
      src_q     <= '0;
      wr_en_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (!stall) begin
        busout_q <= busout_d;
        valid_q  <= valid_d;
        src_q    <= rd_sel;
        wr_en_q  <= wr_oh;
      end
      // A fresh error takes priority over a simultaneous clear.
      if (!stall && (rd_oor || wr_oor)) sel_err_q <= 1'b1;
      else if (err_clr)                 sel_err_q <= 1'b0;
    end
  end

`ifdef BUS_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        cnt_q <= '0;
    else if (!stall && valid_d && |wr_oh) cnt_q <= cnt_q + 1'b1;
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

  assign busout    = busout_q;
  assign bus_valid = valid_q;
  assign bus_src   = src_q;
  assign wr_en     = wr_en_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_bus_xfer_mux.sv
// Scoreboard bench for bus_xfer_mux: directed vectors push expected outputs, a monitor pops and compares.
module tb_bus_xfer_mux;

  localparam int DW = 16, NS = 11, ND = 11, SW = 4, CW = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NS*DW-1:0] src_data;
  logic [SW-1:0]    rd_sel, wr_sel;
  logic             stall, err_clr;
  logic [DW-1:0]    busout;
  logic             bus_valid;
  logic [SW-1:0]    bus_src;
  logic [ND-1:0]    wr_en;
  logic             sel_err;
  logic [CW-1:0]    xfer_cnt;

  typedef struct packed {
    logic [DW-1:0] bo;
    logic          v;
    logic [SW-1:0] bs;
    logic [ND-1:0] we;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  bus_xfer_mux #(.DATA_W(DW), .NUM_SRC(NS), .NUM_DST(ND), .SEL_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .src_data(src_data), .rd_sel(rd_sel), .wr_sel(wr_sel),
    .stall(stall), .err_clr(err_clr), .busout(busout), .bus_valid(bus_valid),
    .bus_src(bus_src), .wr_en(wr_en), .sel_err(sel_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [CW-1:0] cnt_exp(input logic [CW-1:0] c);
`ifdef BUS_XFER_CNT_EN
    return c;
`else
    return '0;
`endif
  endfunction

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".busout"},    32'(busout),    32'(e.bo));
    chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(e.v));
    chk({tag, ".bus_src"},   32'(bus_src),   32'(e.bs));
    chk({tag, ".wr_en"},     32'(wr_en),     32'(e.we));
    chk({tag, ".sel_err"},   32'(sel_err),   32'(e.err));
    chk({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(cnt_exp(e.cnt)));
  endtask

  // Monitor: every output update (1 ns after a rising edge) is matched against the queue head.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) chk_all("vec", exp_q.pop_front());
    end
  end

  task automatic drive(input logic [SW-1:0] rd, input logic [SW-1:0] wr, input logic st,
                       input logic clr, input logic [DW-1:0] bo, input logic v,
                       input logic [SW-1:0] bs, input logic [ND-1:0] we, input logic err,
                       input logic [CW-1:0] cnt);
    @(negedge clock);
    rd_sel  = rd;
    wr_sel  = wr;
    stall   = st;
    err_clr = clr;
    exp_q.push_back('{bo: bo, v: v, bs: bs, we: we, err: err, cnt: cnt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = 16'hA000 | 16'(i);
    src_data[0 +: DW] = 16'h1234;
    rd_sel = '0; wr_sel = '0; stall = 1'b0; err_clr = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", '0);
    @(negedge clock);
    reset_n = 1'b1;

    //     rd  wr  st clr  busout    v  src wr_en          err cnt
    drive(1,  3,  0, 0, 16'h1234, 1, 1,  11'b000_0000_0100, 0, 1);
    drive(5,  1,  0, 0, 16'hA004, 1, 5,  11'b000_0000_0001, 0, 2);
    drive(7,  2,  1, 0, 16'hA004, 1, 5,  11'b000_0000_0001, 0, 2);
    drive(9,  4,  1, 0, 16'hA004, 1, 5,  11'b000_0000_0001, 0, 2);
    drive(2,  6,  1, 0, 16'hA004, 1, 5,  11'b000_0000_0001, 0, 2);
    drive(11, 11, 0, 0, 16'hA00A, 1, 11, 11'b100_0000_0000, 0, 3);
    drive(12, 0,  0, 0, 16'h0000, 0, 12, 11'b000_0000_0000, 1, 3);
    drive(3,  15, 0, 1, 16'hA002, 1, 3,  11'b000_0000_0000, 1, 3);
    drive(0,  0,  0, 1, 16'h0000, 0, 0,  11'b000_0000_0000, 0, 3);
    drive(0,  2,  0, 0, 16'h0000, 0, 0,  11'b000_0000_0010, 0, 3);
    drive(13, 0,  1, 0, 16'h0000, 0, 0,  11'b000_0000_0010, 0, 3);
    drive(11, 1,  0, 0, 16'hA00A, 1, 11, 11'b000_0000_0001, 0, 4);

    // Asynchronous reset mid-cycle while wr_en is asserted.
    @(posedge clock);
    #3;
    chk("pre_reset.wr_en", 32'(wr_en), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", '0);
    @(negedge clock);
    reset_n = 1'b1;
    rd_sel = '0; wr_sel = '0;

    // 17 transfers from reset on a 4-bit counter: 1..15, 0, 1.
    for (int k = 0; k < 17; k++)
      drive(1, 1, 0, 0, 16'h1234, 1, 1, 11'b000_0000_0001, 0, CW'(k + 1));
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 11'b000_0000_0000, 0, 1);

    repeat (2) @(posedge clock);
    #2;
    chk("final.xfer_cnt", 32'(xfer_cnt), 32'(cnt_exp(4'd1)));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
